// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Serial pattern detector with a runtime-loadable pattern and length.
// Bits arrive on w (qualified by en) and are compared against the last
// len_r bits received. The first bit of the pattern is pat_r[len_r-1] and
// the most recent bit is pat_r[0]. z is a Mealy output: it rises in the same
// cycle as the completing bit. Matches are counted in a saturating counter
// with a sticky overflow flag.
//
// Parameters
//   MAXLEN  : maximum pattern length in bits (2..16)
//   CNT_W   : width of match_cnt
//   DEF_PAT : pattern loaded at reset
//   DEF_LEN : pattern length loaded at reset
//
// Ports
//   clk       in   rising-edge clock
//   rstn      in   asynchronous active-low reset
//   en        in   accept w this cycle
//   w         in   serial input bit
//   cfg_load  in   latch pat_in / len_in (clamped) and clear history
//   pat_in    in   [MAXLEN-1:0] new pattern
//   len_in    in   [$clog2(MAXLEN):0] new pattern length
//   overlap   in   1 = overlapping matches, 0 = restart after a match
//   clr_cnt   in   synchronous clear of match_cnt and cnt_ovf
//   z         out  Mealy match (combinational)
//   z_q       out  z delayed by one clock
//   match_cnt out  [CNT_W-1:0] saturating match count
//   cnt_ovf   out  sticky saturation flag
// -----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int                MAXLEN  = 8,
    parameter int                CNT_W   = 8,
    parameter logic [MAXLEN-1:0] DEF_PAT = 8'b0001_0010,
    parameter int                DEF_LEN = 5
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        en,
    input  logic                        w,
    input  logic                        cfg_load,
    input  logic [MAXLEN-1:0]           pat_in,
    input  logic [$clog2(MAXLEN):0]     len_in,
    input  logic                        overlap,
    input  logic                        clr_cnt,
    output logic                        z,
    output logic                        z_q,
    output logic [CNT_W-1:0]            match_cnt,
    output logic                        cnt_ovf
);

    localparam int LW = $clog2(MAXLEN) + 1;  // width of length / fill values
    localparam int HW = MAXLEN - 1;          // history depth in bits

    logic [MAXLEN-1:0] pat_r;
    logic [LW-1:0]     len_r;
    logic [HW-1:0]     hist;    // hist[0] is the most recently accepted bit
    logic [LW-1:0]     fill;    // number of valid bits in hist

    logic [LW-1:0]     len_clamped;
    logic [MAXLEN-1:0] window;  // {history, current bit}; window[0] = w
    logic [MAXLEN-1:0] mask;    // selects the low len_r bits of window
    logic              fill_ok;
    logic              bits_eq;

    // Out-of-range lengths are pulled into 1..MAXLEN so len_r is always usable.
    always_comb begin
        len_clamped = len_in;
        if (len_in == '0) begin
            len_clamped = LW'(1);
        end else if (len_in > LW'(MAXLEN)) begin
            len_clamped = LW'(MAXLEN);
        end
    end

    // The window lines up with the pattern bit-for-bit: window[k] was received
    // k accepted bits before the current one, exactly like pat_r[k].
    assign window = {hist, w};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            mask[i] = (i < int'(len_r));
        end
    end

    // len_r is never 0, so len_r-1 cannot wrap. With len_r=1 this is always
    // true, leaving only the w == pat_r[0] test.
    assign fill_ok = (fill >= (len_r - LW'(1)));
    assign bits_eq = (((window ^ pat_r) & mask) == '0);

    // Gating by rstn keeps z low during reset even if DEF_LEN is 1.
    assign z = rstn & en & ~cfg_load & fill_ok & bits_eq;

    // Pattern, history and fill.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pat_r <= DEF_PAT;
            len_r <= LW'(DEF_LEN);
            hist  <= '0;
            fill  <= '0;
        end else if (cfg_load) begin
            // w is ignored during a load; stale history is invalidated by fill.
            pat_r <= pat_in;
            len_r <= len_clamped;
            fill  <= '0;
        end else if (en) begin
            hist <= window[HW-1:0];
            if (z && !overlap) begin
                // Non-overlapping mode: no bit of this match may be reused.
                fill <= '0;
            end else if (fill != LW'(HW)) begin
                fill <= fill + LW'(1);
            end
        end
    end

    // Delayed match and saturating counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            z_q       <= 1'b0;
            match_cnt <= '0;
            cnt_ovf   <= 1'b0;
        end else begin
            z_q <= z;
            if (clr_cnt) begin
                // Clear wins over a simultaneous match.
                match_cnt <= '0;
                cnt_ovf   <= 1'b0;
            end else if (z) begin
                if (match_cnt == '1) begin
                    cnt_ovf <= 1'b1;
                end else begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
//
// Drives two detectors from the same inputs: one with default parameters and
// one with a 2-bit counter for saturation behaviour. Expected values come from
// directed tables and from a bit-queue reference model of the matching rules.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

    localparam int MAXLEN = 8;
    localparam logic [7:0] DEF_PAT = 8'b0001_0010;
    localparam int DEF_LEN = 5;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rstn;
    logic       en, w, cfg_load, overlap, clr_cnt;
    logic [7:0] pat_in;
    logic [3:0] len_in;

    logic       z, z_q, cnt_ovf;
    logic [7:0] match_cnt;
    logic       z2, z_q2, cnt_ovf2;
    logic [1:0] match_cnt2;

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk(clk), .rstn(rstn), .en(en), .w(w), .cfg_load(cfg_load),
        .pat_in(pat_in), .len_in(len_in), .overlap(overlap), .clr_cnt(clr_cnt),
        .z(z), .z_q(z_q), .match_cnt(match_cnt), .cnt_ovf(cnt_ovf)
    );

    seq_detect_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rstn(rstn), .en(en), .w(w), .cfg_load(cfg_load),
        .pat_in(pat_in), .len_in(len_in), .overlap(overlap), .clr_cnt(clr_cnt),
        .z(z2), .z_q(z_q2), .match_cnt(match_cnt2), .cnt_ovf(cnt_ovf2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    logic [7:0] m_pat;
    int         m_len;
    bit         m_hist[$];   // accepted bits since last restart, oldest first
    int         m_cnt, m_cnt2;
    bit         m_ovf, m_ovf2;
    bit         exp_z;

    // Sampled DUT values from the last tick.
    logic       obs_z, obs_z2, obs_zq, obs_zq2, obs_ovf, obs_ovf2;
    logic [7:0] obs_cnt;
    logic [1:0] obs_cnt2;

    function automatic int clamp_len(input logic [3:0] l);
        if (l == 0) return 1;
        if (int'(l) > MAXLEN) return MAXLEN;
        return int'(l);
    endfunction

    function automatic bit model_z();
        if (rstn !== 1'b1 || en !== 1'b1 || cfg_load !== 1'b0) return 1'b0;
        if (m_hist.size() < m_len - 1) return 1'b0;
        if (w !== m_pat[0]) return 1'b0;
        for (int k = 1; k < m_len; k++) begin
            if (m_hist[m_hist.size() - k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_reset();
        m_pat = DEF_PAT;
        m_len = DEF_LEN;
        m_hist.delete();
        m_cnt = 0; m_cnt2 = 0;
        m_ovf = 1'b0; m_ovf2 = 1'b0;
    endfunction

    function automatic void model_edge(input bit zz);
        if (cfg_load) begin
            m_pat = pat_in;
            m_len = clamp_len(len_in);
            m_hist.delete();
        end else if (en) begin
            if (zz && !overlap) begin
                m_hist.delete();
            end else begin
                m_hist.push_back(w);
                if (m_hist.size() > MAXLEN - 1) void'(m_hist.pop_front());
            end
        end
        if (clr_cnt) begin
            m_cnt = 0; m_cnt2 = 0; m_ovf = 1'b0; m_ovf2 = 1'b0;
        end else if (zz) begin
            if (m_cnt == 255) m_ovf = 1'b1; else m_cnt++;
            if (m_cnt2 == 3) m_ovf2 = 1'b1; else m_cnt2++;
        end
    endfunction

    // ---------------- driver tasks ----------------
    // One clock: inputs change after the falling edge, z is sampled before the
    // rising edge, registered outputs 1 time unit after it.
    task automatic tick(input logic i_en, input logic i_w, input logic i_cfg,
                        input logic i_clr, input logic i_ov);
        @(negedge clk);
        en = i_en; w = i_w; cfg_load = i_cfg; clr_cnt = i_clr; overlap = i_ov;
        #1;
        exp_z  = model_z();
        obs_z  = z;
        obs_z2 = z2;
        @(posedge clk);
        model_edge(exp_z);
        #1;
        obs_zq = z_q;  obs_zq2 = z_q2;
        obs_cnt = match_cnt; obs_cnt2 = match_cnt2;
        obs_ovf = cnt_ovf;   obs_ovf2 = cnt_ovf2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; en = 1'b0; w = 1'b0; cfg_load = 1'b0; clr_cnt = 1'b0;
        overlap = 1'b1; pat_in = '0; len_in = '0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0; en = 1'b1; w = 1'b0; cfg_load = 1'b0; clr_cnt = 1'b0;
        overlap = 1'b1; pat_in = '0; len_in = '0;
        model_reset();
        #3;
        n_checks++;
        if (z !== 1'b0 || z2 !== 1'b0) begin
            n_errors++; $display("FAIL reset_z: got %b/%b expected 0", z, z2);
        end
        n_checks++;
        if (z_q !== 1'b0 || match_cnt !== 8'd0 || cnt_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_regs: got z_q=%b cnt=%0d ovf=%b expected 0/0/0", z_q, match_cnt, cnt_ovf);
        end
        n_checks++;
        if (match_cnt2 !== 2'd0 || cnt_ovf2 !== 1'b0) begin
            n_errors++; $display("FAIL reset_regs2: got cnt=%0d ovf=%b expected 0/0", match_cnt2, cnt_ovf2);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic run_stream(input string name, input logic ov, input logic [7:0] zexp);
        logic [7:0] s;
        s = 8'b1001_0010;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, s[7-i], 1'b0, 1'b0, ov);
            n_checks++;
            if (obs_z !== zexp[7-i] || obs_z2 !== zexp[7-i]) begin
                n_errors++;
                $display("FAIL %s_z bit%0d: got %b/%b expected %b", name, i+1, obs_z, obs_z2, zexp[7-i]);
            end
            n_checks++;
            if (obs_zq !== zexp[7-i]) begin
                n_errors++;
                $display("FAIL %s_zq bit%0d: got %b expected %b", name, i+1, obs_zq, zexp[7-i]);
            end
        end
    endtask

    task automatic test_overlap();
        do_reset();
        run_stream("overlap", 1'b1, 8'b0000_1001);
        n_checks++;
        if (obs_cnt !== 8'd2 || obs_cnt2 !== 2'd2) begin
            n_errors++; $display("FAIL overlap_cnt: got %0d/%0d expected 2", obs_cnt, obs_cnt2);
        end
    endtask

    task automatic test_non_overlap();
        do_reset();
        run_stream("nonoverlap", 1'b0, 8'b0000_1000);
        n_checks++;
        if (obs_cnt !== 8'd1) begin
            n_errors++; $display("FAIL nonoverlap_cnt: got %0d expected 1", obs_cnt);
        end
    endtask

    task automatic test_reload();
        logic [3:0] s;
        logic [3:0] zexp;
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        // w=0 here would complete 10010 if it were accepted.
        pat_in = 8'b0000_0011; len_in = 4'd3;
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs_z !== 1'b0) begin
            n_errors++; $display("FAIL reload_cfg_z: got %b expected 0", obs_z);
        end
        pat_in = 8'hFF; len_in = 4'd1;   // must not affect z after the load
        s = 4'b0111; zexp = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, s[3-i], 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (obs_z !== zexp[3-i]) begin
                n_errors++; $display("FAIL reload_z bit%0d: got %b expected %b", i+1, obs_z, zexp[3-i]);
            end
        end
        n_checks++;
        if (obs_cnt !== 8'd1) begin
            n_errors++; $display("FAIL reload_cnt: got %0d expected 1", obs_cnt);
        end
    endtask

    task automatic test_counter();
        do_reset();
        pat_in = 8'd1; len_in = 4'd1;
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (obs_z !== 1'b1) begin
                n_errors++; $display("FAIL cnt_z match%0d: got %b expected 1", i, obs_z);
            end
            n_checks++;
            if (obs_cnt2 !== 2'((i > 3) ? 3 : i) || obs_ovf2 !== (i >= 4)) begin
                n_errors++;
                $display("FAIL cnt_sat match%0d: got cnt=%0d ovf=%b expected cnt=%0d ovf=%b",
                         i, obs_cnt2, obs_ovf2, (i > 3) ? 3 : i, (i >= 4));
            end
        end
        n_checks++;
        if (obs_cnt !== 8'd5 || obs_ovf !== 1'b0) begin
            n_errors++; $display("FAIL cnt_wide: got %0d/%b expected 5/0", obs_cnt, obs_ovf);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (obs_cnt2 !== 2'd0 || obs_ovf2 !== 1'b0 || obs_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL cnt_clear: got %0d/%b/%0d expected 0/0/0", obs_cnt2, obs_ovf2, obs_cnt);
        end
        n_checks++;
        if (obs_zq !== 1'b1) begin
            n_errors++; $display("FAIL cnt_clear_zq: got %b expected 1", obs_zq);
        end
    endtask

    task automatic test_len_clamp();
        logic [7:0] s;
        do_reset();
        // Length 12 must clamp to 8: match only after all 8 bits of A5.
        pat_in = 8'hA5; len_in = 4'd12;
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        s = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, s[7-i], 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (obs_z !== (i == 7)) begin
                n_errors++; $display("FAIL clamp_hi bit%0d: got %b expected %b", i+1, obs_z, (i == 7));
            end
        end
        // Length 0 must clamp to 1: every w=0 matches pat[0]=0.
        pat_in = 8'hFE; len_in = 4'd0;
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (obs_z !== 1'b1) begin
            n_errors++; $display("FAIL clamp_zero: got %b expected 1", obs_z);
        end
    endtask

    task automatic test_gating();
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);   // idle bit must be ignored
        n_checks++;
        if (obs_z !== 1'b0) begin
            n_errors++; $display("FAIL gate_idle_z: got %b expected 0", obs_z);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (obs_z !== 1'b1 || obs_cnt !== 8'd1) begin
            n_errors++; $display("FAIL gate_match: got z=%b cnt=%0d expected 1/1", obs_z, obs_cnt);
        end
        // Mid-stream reset discards the partial 1001.
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if (z_q !== 1'b0 || match_cnt !== 8'd0) begin
            n_errors++; $display("FAIL gate_rst_regs: got z_q=%b cnt=%0d expected 0/0", z_q, match_cnt);
        end
        rstn = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (obs_z !== 1'b0) begin
            n_errors++; $display("FAIL gate_rst_z: got %b expected 0", obs_z);
        end
    endtask

    task automatic test_random();
        logic r_en, r_w, r_cfg, r_clr, r_ov;
        do_reset();
        pat_in = 8'($urandom); len_in = 4'd3;
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            pat_in = 8'($urandom);
            len_in = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(1, 3));
            r_cfg = ($urandom_range(0, 40) == 0);
            r_clr = ($urandom_range(0, 60) == 0);
            r_en  = ($urandom_range(0, 7) != 0);
            r_ov  = 1'($urandom_range(0, 1));
            r_w   = 1'($urandom_range(0, 1));
            tick(r_en, r_w, r_cfg, r_clr, r_ov);
            n_checks++;
            if (obs_z !== exp_z || obs_z2 !== exp_z) begin
                n_errors++; $display("FAIL rand_z cyc%0d: got %b/%b expected %b", i, obs_z, obs_z2, exp_z);
            end
            n_checks++;
            if (obs_zq !== exp_z || obs_zq2 !== exp_z) begin
                n_errors++; $display("FAIL rand_zq cyc%0d: got %b/%b expected %b", i, obs_zq, obs_zq2, exp_z);
            end
            n_checks++;
            if (obs_cnt !== 8'(m_cnt) || obs_ovf !== m_ovf) begin
                n_errors++;
                $display("FAIL rand_cnt cyc%0d: got %0d/%b expected %0d/%b", i, obs_cnt, obs_ovf, m_cnt, m_ovf);
            end
            n_checks++;
            if (obs_cnt2 !== 2'(m_cnt2) || obs_ovf2 !== m_ovf2) begin
                n_errors++;
                $display("FAIL rand_cnt2 cyc%0d: got %0d/%b expected %0d/%b", i, obs_cnt2, obs_ovf2, m_cnt2, m_ovf2);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_reload();
        test_counter();
        test_len_clamp();
        test_gating();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter MAXLEN, default 8, maximum pattern length in bits (2..16).
REQ-002 SHALL have parameter CNT_W, default 8, match-counter width.
REQ-003 SHALL have parameter DEF_PAT, default 8'b0001_0010, pattern loaded at reset.
REQ-004 SHALL have parameter DEF_LEN, default 5, length loaded at reset.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- en  in  1  accept w this cycle.
- w  in  1  serial input bit.
- cfg_load  in  1  latch pat_in/len_in and clear history.
- pat_in  in  MAXLEN  pattern; bit len-1 is the first bit received, bit 0 the last.
- len_in  in  clog2(MAXLEN)+1  pattern length.
- overlap  in  1  1 = overlapping matches, 0 = restart after a match.
- clr_cnt  in  1  synchronous clear of match_cnt and cnt_ovf.
- z  out  1  Mealy match, combinational from w and state.
- z_q  out  1  z registered (one-cycle delay).
- match_cnt  out  CNT_W  saturating match count.
- cnt_ovf  out  1  sticky saturation flag.

Function
REQ-006 SHALL hold registers pat_r, len_r, hist (last MAXLEN-1 accepted bits) and fill (count of valid history bits, saturating at MAXLEN-1).
REQ-007 SHALL clamp a loaded length: len_in of 0 loads 1; len_in > MAXLEN loads MAXLEN.
REQ-008 Match condition: en=1, cfg_load=0, fill >= len_r-1, and the window of the last len_r-1 accepted bits followed by the current w equals pat_r[len_r-1:0].
REQ-009 SHALL drive z=1 in the same cycle as the match condition (Mealy), else z=0; z SHALL NOT depend on pat_in or len_in.
REQ-010 On a clock edge with en=1 and cfg_load=0, SHALL shift w into hist and increment fill (saturating).
REQ-011 With overlap=0, on a matching edge, SHALL clear fill to 0 instead of incrementing, so no bit participates in two matches.
REQ-012 With overlap=1, on a matching edge, SHALL shift and increment normally.
REQ-013 With en=0, SHALL hold hist, fill and counter, and drive z=0.
REQ-014 On cfg_load=1, SHALL latch pat_in and the clamped len_in, clear fill to 0, and ignore w; z=0 that cycle regardless of en.
REQ-015 SHALL register z_q <= z on every edge.
REQ-016 SHALL increment match_cnt on each edge where z=1.
REQ-017 At the all-ones value, a further match SHALL hold match_cnt and set cnt_ovf.
REQ-018 clr_cnt=1 SHALL force match_cnt=0 and cnt_ovf=0 on that edge; clear SHALL win over a simultaneous match.
REQ-019 The overlap input SHALL take effect on the edge at which it is sampled; no restart is implied by a change of overlap.
REQ-020 With len_r=1, the match condition SHALL be w==pat_r[0] with no history requirement.

Reset
REQ-021 rstn=0 SHALL asynchronously set pat_r=DEF_PAT, len_r=DEF_LEN, hist=0, fill=0, z_q=0, match_cnt=0, cnt_ovf=0.
REQ-022 z SHALL be 0 while rstn=0.
REQ-023 Deassertion of rstn SHALL take effect at the next rising edge; a mid-stream reset SHALL discard partial matches.

Verification
REQ-024 Overlap case: after reset, overlap=1, en=1, w=1,0,0,1,0,0,1,0 -> z=1 on bits 5 and 8; z_q=1 one cycle later each; match_cnt=2.
REQ-025 Non-overlap case: same stream with overlap=0 -> z=1 on bit 5 only; match_cnt=1.
REQ-026 Reload case: cfg_load with pat_in=3'b011, len_in=3 while a partial match is pending (w not accepted that cycle), then w=0,1,1,1 -> single z on the 3rd bit; no match from pre-load history.
REQ-027 Counter/clear case: CNT_W=2, len_in=1, pat_in=1, w=1 for 5 cycles -> match_cnt=3 and cnt_ovf=1 after the 4th match; clr_cnt asserted with a match -> match_cnt=0, cnt_ovf=0.
REQ-028 Gating case: en=0 inserted between bits 3 and 4 of 10010 -> match still on bit 5; rstn pulsed after bit 4 -> no match on bit 5.
